// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: 2-flop synchronizer, per-channel stability counter, registered edge pulses.
// Define BTN_DEBOUNCE_FALL_EN to add the btn_fall port and its 1->0 pulse logic.
module btn_debounce_lane #(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
`ifdef BTN_DEBOUNCE_FALL_EN
  ,
  output logic fall
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
`ifdef BTN_DEBOUNCE_FALL_EN
  assign fall  = fall_q;
`else
  logic unused_fall;
  assign unused_fall = fall_q;
`endif
endmodule

module btn_debounce #(
  parameter int NUM_BTN       = 4,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise
`ifdef BTN_DEBOUNCE_FALL_EN
  ,
  output logic [NUM_BTN-1:0] btn_fall
`endif
);
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_debounce_lane #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in[g]),
      .level (btn_level[g]),
      .rise  (btn_rise[g])
`ifdef BTN_DEBOUNCE_FALL_EN
      ,
      .fall  (btn_fall[g])
`endif
    );
  end
endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (NUM_BTN=4, STABLE_CYCLES=4) with a window-based reference model.
module tb_btn_debounce;
  localparam int NB = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, btn_rise;
`ifdef BTN_DEBOUNCE_FALL_EN
  logic [NB-1:0] btn_fall;
`endif

  int checks = 0;
  int failures = 0;

  btn_debounce #(.NUM_BTN(NB), .STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise)
`ifdef BTN_DEBOUNCE_FALL_EN
    ,
    .btn_fall (btn_fall)
`endif
  );

  always #5 clk = ~clk;

  // Reference: the value seen at each edge is the raw input from two edges earlier
  // (zero across reset); a channel flips once its last S seen values all disagree with it.
  logic [NB-1:0] pend0 = '0, pend1 = '0;
  logic [NB-1:0] seen_q[$];
  logic [NB-1:0] m_level = '0, m_rise = '0, m_fall = '0;

  function automatic logic [NB-1:0] next_level(input logic [NB-1:0] lvl);
    logic [NB-1:0] n;
    n = lvl;
    if (seen_q.size() == S)
      for (int c = 0; c < NB; c++) begin
        bit flip;
        flip = 1'b1;
        foreach (seen_q[j]) if (seen_q[j][c] == lvl[c]) flip = 1'b0;
        if (flip) n[c] = ~lvl[c];
      end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pend0 <= '0;
      pend1 <= '0;
      seen_q.delete();
      m_level <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
    end else begin
      seen_q.push_back(pend0);
      if (seen_q.size() > S) void'(seen_q.pop_front());
      pend0   <= pend1;
      pend1   <= btn_in;
      m_level <= next_level(m_level);
      m_rise  <= next_level(m_level) & ~m_level;
      m_fall  <= ~next_level(m_level) & m_level;
    end
  end

  task automatic clean_reset(input logic [NB-1:0] b);
    rst = 1'b1; btn_in = b;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    bit found;
    rst = 1'b1; btn_in = 4'hF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_rise} !== 8'h00) begin
        failures++; $display("FAIL reset_hold got=%h want=00", {btn_level, btn_rise});
      end
    end
    rst = 1'b0;
    found = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_rise} !== {m_level, m_rise}) begin
        failures++; $display("FAIL reset_model e=%0d got=%h want=%h", e, {btn_level, btn_rise}, {m_level, m_rise});
      end
      if (!found && btn_level == 4'hF) begin
        found = 1'b1;
        checks++;
        if (e != 6 || btn_rise !== 4'hF) begin
          failures++; $display("FAIL reset_release edge=%0d rise=%h want edge=6 rise=f", e, btn_rise);
        end
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reset_release level never reached f"); end
  endtask

  task automatic test_press;
    clean_reset(4'h0);
    btn_in = 4'b0001;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      checks++;
      if (btn_level[0] !== (e >= 6) || btn_rise[0] !== (e == 6)) begin
        failures++; $display("FAIL press e=%0d got lvl=%b rise=%b want lvl=%b rise=%b",
                             e, btn_level[0], btn_rise[0], e >= 6, e == 6);
      end
    end
  endtask

  task automatic test_bounce;
    int pulses;
    clean_reset(4'h0);
    pulses = 0;
    repeat (5) begin
      btn_in[1] = 1'b1;
      repeat (3) begin @(negedge clk); pulses += int'(btn_rise[1]); end
      btn_in[1] = 1'b0;
      @(negedge clk); pulses += int'(btn_rise[1]);
    end
    checks++;
    if (pulses != 0 || btn_level[1] !== 1'b0) begin
      failures++; $display("FAIL bounce_glitch pulses=%0d lvl=%b want 0 0", pulses, btn_level[1]);
    end
    btn_in[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if (btn_rise[1] !== (e == 6) || btn_level[1] !== (e >= 6)) begin
        failures++; $display("FAIL bounce_settle e=%0d got rise=%b lvl=%b", e, btn_rise[1], btn_level[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    clean_reset(4'h0);
    btn_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; btn_in = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (btn_level[2] !== 1'b0 || btn_rise[2] !== 1'b0) begin
        failures++; $display("FAIL reset_mid e=%0d got lvl=%b rise=%b want 0 0", e, btn_level[2], btn_rise[2]);
      end
    end
  endtask

  task automatic test_simultaneous;
    clean_reset(4'h0);
    btn_in = 4'b1100;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (btn_rise !== ((e == 6) ? 4'b1100 : 4'b0000) || btn_level !== ((e >= 6) ? 4'b1100 : 4'b0000)) begin
        failures++; $display("FAIL simultaneous e=%0d got rise=%b lvl=%b", e, btn_rise, btn_level);
      end
    end
  endtask

`ifdef BTN_DEBOUNCE_FALL_EN
  task automatic test_fall;
    clean_reset(4'h0);
    btn_in = 4'b0001;
    repeat (8) @(negedge clk);
    btn_in = 4'b0000;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (btn_fall[0] !== (e == 6) || btn_level[0] !== (e < 6) || btn_rise !== 4'b0000) begin
        failures++; $display("FAIL fall e=%0d got fall=%b lvl=%b rise=%b", e, btn_fall[0], btn_level[0], btn_rise);
      end
    end
  endtask
`endif

  task automatic test_random;
    int hold;
    clean_reset(4'h0);
    hold = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_rise} !== {m_level, m_rise}) begin
        failures++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, {btn_level, btn_rise}, {m_level, m_rise});
      end
`ifdef BTN_DEBOUNCE_FALL_EN
      checks++;
      if (btn_fall !== m_fall) begin
        failures++; $display("FAIL random_fall cyc=%0d got=%h want=%h", cyc, btn_fall, m_fall);
      end
`endif
      rst = ($urandom_range(0, 80) == 0);
      if (hold == 0) begin
        btn_in = NB'($urandom);
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
`ifdef BTN_DEBOUNCE_FALL_EN
    test_fall();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter NUM_BTN, default 4, number of independent button channels (1..8).
REQ-002 Parameter STABLE_CYCLES, default 1000000, consecutive cycles a synchronized input must hold a new value before it is accepted (minimum 2).
REQ-003 Port clk  input  1  single clock domain, rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port btn_in  input  NUM_BTN  raw asynchronous button levels, one bit per channel.
REQ-006 Port btn_level  output  NUM_BTN  debounced stable level per channel.
REQ-007 Port btn_rise  output  NUM_BTN  one-cycle pulse per channel on each accepted 0->1 transition.
REQ-008 Port btn_fall  output  NUM_BTN  one-cycle pulse per channel on each accepted 1->0 transition; present only when the macro in REQ-024 is defined.

Function
REQ-009 Each channel SHALL pass btn_in through a two-flop synchronizer; the second flop's output is the sync value.
REQ-010 Each channel SHALL own a counter of width clog2(STABLE_CYCLES), with no sharing between channels.
REQ-011 When sync equals btn_level, the counter SHALL be cleared to 0 on the next edge.
REQ-012 When sync differs from btn_level and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When sync differs from btn_level and the counter equals STABLE_CYCLES-1, the next edge SHALL set btn_level to sync and clear the counter; the counter never wraps.
REQ-014 A raw change held steady SHALL appear on btn_level exactly STABLE_CYCLES+2 rising edges after the first edge that samples it.
REQ-015 Any mismatch shorter than STABLE_CYCLES cycles (glitch or bounce) SHALL restart the count from 0 and SHALL NOT change btn_level or produce a pulse.
REQ-016 btn_rise SHALL be registered and high for exactly the one cycle in which btn_level first reads 1 after reading 0; it SHALL be 0 in all other cycles.
REQ-017 Holding a button indefinitely SHALL produce exactly one btn_rise pulse; no auto-repeat.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.
REQ-019 All outputs SHALL be driven directly from flops, with no combinational path from btn_in.

Reset
REQ-020 While rst is high at a clock edge, the synchronizer flops, counters, btn_level, btn_rise and btn_fall SHALL all be cleared to 0.
REQ-021 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted for that transition.
REQ-022 A button held high through reset SHALL be treated as a new press after reset: btn_level rises STABLE_CYCLES+2 edges after rst deasserts, with one btn_rise pulse.
REQ-023 There SHALL be no reset-release pulse on any output.

Configuration
REQ-024 With macro BTN_DEBOUNCE_FALL_EN defined, the btn_fall port and its logic SHALL exist, mirroring REQ-016 and REQ-017 for accepted 1->0 transitions.
REQ-025 Without BTN_DEBOUNCE_FALL_EN, the btn_fall port SHALL be absent; all other behaviour is unchanged.

Verification (NUM_BTN=4, STABLE_CYCLES=4)
REQ-026 Reset for 3 cycles with btn_in=4'hF -> all outputs 0 during reset; btn_level=4'hF first seen 6 edges after rst deasserts, with btn_rise=4'hF for that single cycle.
REQ-027 btn_in[0] 0->1 held steady -> btn_level[0]=1 and btn_rise[0]=1 at edge 6; btn_rise[0]=0 on every later edge while held.
REQ-028 btn_in[1] toggled high for 3 cycles, low for 1, repeated 5 times, then held high -> no btn_rise[1] during bounce; exactly one pulse 6 edges after final steady high.
REQ-029 btn_in[2] high for 2 cycles, then rst asserted in the middle of the count -> btn_level[2] stays 0 and no pulse is emitted.
REQ-030 btn_in[3:2] rise on the same edge -> btn_rise=4'b1100 on a single cycle; channels 0 and 1 unaffected.
REQ-031 With BTN_DEBOUNCE_FALL_EN defined, btn_in[0] 1->0 after being accepted high -> btn_level[0]=0 and btn_fall[0]=1 for one cycle at edge 6; btn_rise stays 0.
